if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one SRAM read per cycle, tracks the fetched PC,
// and buffers returned instructions while ID stalls so none are lost or duplicated.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // Handshake: an instruction moves IF->ID on a cycle where fs_to_ds_valid and
  // ds_allowin are both 1; fs_allowin says IF can accept a new fetch that cycle.
  logic        started_q,      started_d;
  logic        fs_valid_q,     fs_valid_d;
  logic [31:0] fs_pc_q,        fs_pc_d;
  logic        rdata_fresh_q,  rdata_fresh_d;
  logic [31:0] inst_buf_q,     inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign br_taken    = br_bus[32];
  assign br_target   = br_bus[31:0];
  assign redirect    = br_taken & ds_allowin;
  assign to_fs_valid = started_q;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid_q | (fs_ready_go & ds_allowin);
  assign nextpc      = redirect ? br_target : (fs_pc_q + 32'd4);

  // A branch stalled in ID freezes fetch so its target cannot be lost.
  assign inst_sram_en    = to_fs_valid & fs_allowin & !(br_taken & !ds_allowin);
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign fs_inst        = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid_q & !br_taken;
  assign fs_to_ds_bus   = {fs_inst, fs_pc_q};

  always_comb begin
    started_d        = 1'b1;
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    rdata_fresh_d    = 1'b0;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    if (inst_sram_en) begin
      fs_pc_d          = nextpc;
      fs_valid_d       = 1'b1;
      rdata_fresh_d    = 1'b1;
      inst_buf_valid_d = 1'b0;
    end else begin
      if ((fs_valid_q & ds_allowin) | redirect) begin
        fs_valid_d       = 1'b0;
        inst_buf_valid_d = 1'b0;
      end
      // SRAM data is only present for one cycle; keep it if ID cannot take it now.
      if (fs_valid_q & rdata_fresh_q & !ds_allowin & !redirect) begin
        inst_buf_d       = inst_sram_rdata;
        inst_buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q        <= 1'b0;
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      rdata_fresh_q    <= 1'b0;
      inst_buf_q       <= 32'h0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      started_q        <= started_d;
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      rdata_fresh_q    <= rdata_fresh_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

endmodule
